// File: rtl/mtm_alu_pkg.sv
// Shared definitions for the ALU serial front end.
// Opcodes, error codes, frame fields and CRC-4 helpers.
package mtm_alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101
    } op_t;

    localparam logic [5:0] ERR_NONE = 6'b000000;
    localparam logic [5:0] ERR_DATA = 6'b100100;
    localparam logic [5:0] ERR_CRC  = 6'b010010;
    localparam logic [5:0] ERR_OP   = 6'b001001;

    localparam logic FRAME_DATA = 1'b0;
    localparam logic FRAME_CMD  = 1'b1;

    localparam int PAYLOAD_BITS = 8;
    localparam int CMD_OP_MSB   = 6;
    localparam int CMD_OP_LSB   = 4;
    localparam int CMD_CRC_MSB  = 3;
    localparam int CMD_CRC_LSB  = 0;

    // x^4 + x + 1, the x^4 term is implicit
    localparam logic [3:0] CRC4_POLY = 4'b0011;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_TYPE,
        RX_PAYLOAD,
        RX_STOP
    } rx_state_t;

    function automatic logic [3:0] next_crc4(
        input logic [3:0] crc,
        input logic       din
    );
        logic fb;
        fb = crc[3] ^ din;
        return {crc[2:0], 1'b0} ^ ({4{fb}} & CRC4_POLY);
    endfunction

    function automatic logic op_is_valid(input logic [2:0] op);
        return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB};
    endfunction

endpackage

// File: rtl/mtm_alu_rx_frame.sv
// Bit-level frame receiver: start, type, 8 payload bits, stop.
// Frame outputs are valid while the stop bit is on the line.
module mtm_alu_rx_frame
    import mtm_alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       sin,
    output logic       frame_done,
    output logic       frame_type,
    output logic [7:0] payload,
    output logic       frame_err,
    output logic       bit_valid,
    output logic       bit_data
);

    rx_state_t   state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        type_q, type_d;
    logic [7:0]  payload_q, payload_d;
    logic        armed_q, armed_d;

    // Next-state: armed only once the line is seen idle after reset
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        type_d    = type_q;
        payload_d = payload_q;
        armed_d   = armed_q;
        unique case (state_q)
            RX_IDLE: begin
                if (sin)
                    armed_d = 1'b1;
                if (!sin && armed_q)
                    state_d = RX_TYPE;
            end
            RX_TYPE: begin
                type_d    = sin;
                bit_cnt_d = 3'd0;
                state_d   = RX_PAYLOAD;
            end
            RX_PAYLOAD: begin
                payload_d = {payload_q[6:0], sin};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'(PAYLOAD_BITS - 1))
                    state_d = RX_STOP;
            end
            RX_STOP: begin
                state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Frame state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RX_IDLE;
            bit_cnt_q <= 3'd0;
            type_q    <= 1'b0;
            payload_q <= 8'd0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            type_q    <= type_d;
            payload_q <= payload_d;
            armed_q   <= armed_d;
        end
    end

    assign frame_done = (state_q == RX_STOP);
    assign frame_err  = frame_done & ~sin;
    assign frame_type = type_q;
    assign payload    = payload_q;
    assign bit_valid  = (state_q == RX_PAYLOAD) & (type_q == FRAME_DATA);
    assign bit_data   = sin;

endmodule

// File: rtl/mtm_alu_deserializer.sv
// Serial receive front end of the ALU.
// Counts data frames, accumulates CRC-4, checks and registers outputs.
module mtm_alu_deserializer
    import mtm_alu_pkg::*;
#(
    parameter int DATA_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sin,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [2:0]  OP,
    output logic [5:0]  ERR_FLAGS,
    output logic        out_valid
);

    localparam int CNT_W = $clog2(DATA_FRAMES + 2);

    logic        frame_done;
    logic        frame_type;
    logic [7:0]  payload;
    logic        frame_err;
    logic        bit_valid;
    logic        bit_data;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       crc_q, crc_d;
    logic [3:0]       crc_fin;
    logic [63:0]      sr_q, sr_d;
    logic [31:0]      a_q, a_d, b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [5:0]       err_q, err_d;
    logic             valid_q, valid_d;

    mtm_alu_rx_frame u_rx (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .frame_done (frame_done),
        .frame_type (frame_type),
        .payload    (payload),
        .frame_err  (frame_err),
        .bit_valid  (bit_valid),
        .bit_data   (bit_data)
    );

    // CRC finalised with the marker bit and the three opcode bits
    always_comb begin
        crc_fin = next_crc4(crc_q, 1'b1);
        for (int i = 2; i >= 0; i--)
            crc_fin = next_crc4(crc_fin, payload[CMD_OP_LSB+i]);
    end

    // Packet assembly, checks and output update
    always_comb begin
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        sr_d    = sr_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        err_d   = err_q;
        valid_d = 1'b0;
        if (bit_valid)
            crc_d = next_crc4(crc_q, bit_data);
        if (frame_done) begin
            if (frame_err) begin
                valid_d = 1'b1;
                err_d   = ERR_DATA;
                a_d     = sr_q[31:0];
                b_d     = sr_q[63:32];
                cnt_d   = '0;
                crc_d   = 4'd0;
            end else if (frame_type == FRAME_DATA) begin
                sr_d = {sr_q[55:0], payload};
                if (cnt_q != CNT_W'(DATA_FRAMES + 1))
                    cnt_d = cnt_q + CNT_W'(1);
            end else begin
                valid_d = 1'b1;
                a_d     = sr_q[31:0];
                b_d     = sr_q[63:32];
                op_d    = payload[CMD_OP_MSB:CMD_OP_LSB];
                cnt_d   = '0;
                crc_d   = 4'd0;
                if (cnt_q != CNT_W'(DATA_FRAMES))
                    err_d = ERR_DATA;
                else if (crc_fin != payload[CMD_CRC_MSB:CMD_CRC_LSB])
                    err_d = ERR_CRC;
                else if (!op_is_valid(payload[CMD_OP_MSB:CMD_OP_LSB]))
                    err_d = ERR_OP;
                else
                    err_d = ERR_NONE;
            end
        end
    end

    // Packet state and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            crc_q   <= 4'd0;
            sr_q    <= 64'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 3'd0;
            err_q   <= ERR_NONE;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            sr_q    <= sr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign OP        = op_q;
    assign ERR_FLAGS = err_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Bench for the ALU serial front end.
// Random packets checked against a CRC long-division reference model.
module tb_mtm_alu_deserializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        sin;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  OP;
    logic [5:0]  ERR_FLAGS;
    logic        out_valid;

    int total   = 0;
    int bad     = 0;
    int nstrobe = 0;

    typedef struct {
        logic        v0;
        logic        v1;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [5:0]  err;
    } obs_t;

    mtm_alu_deserializer #(.DATA_FRAMES(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .A         (A),
        .B         (B),
        .OP        (OP),
        .ERR_FLAGS (ERR_FLAGS),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (out_valid === 1'b1)
            nstrobe++;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Remainder of {B,A,1,OP} * x^4 divided by x^4+x+1
    function automatic logic [3:0] crc_ref(
        input logic [31:0] b,
        input logic [31:0] a,
        input logic [2:0]  op
    );
        logic [71:0] m;
        m = {b, a, 1'b1, op, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (m[i])
                m[i -: 5] = m[i -: 5] ^ 5'b10011;
        return m[3:0];
    endfunction

    function automatic logic [5:0] exp_err(
        input int         nd,
        input logic [3:0] cx,
        input logic [2:0] op
    );
        if (nd != 8)
            return 6'b100100;
        if (cx != 4'd0)
            return 6'b010010;
        if (!(op inside {3'b000, 3'b001, 3'b100, 3'b101}))
            return 6'b001001;
        return 6'b000000;
    endfunction

    task automatic send_bit(input logic b);
        @(negedge clk);
        sin = b;
    endtask

    task automatic send_frame(
        input logic       typ,
        input logic [7:0] d,
        input logic       stop
    );
        send_bit(1'b0);
        send_bit(typ);
        for (int i = 7; i >= 0; i--)
            send_bit(d[i]);
        send_bit(stop);
    endtask

    // Sample the cycle right after the stop bit, then the one after
    task automatic capture(output obs_t o);
        @(negedge clk);
        sin  = 1'b1;
        o.v0 = out_valid;
        o.a  = A;
        o.b  = B;
        o.op = OP;
        o.err = ERR_FLAGS;
        @(negedge clk);
        o.v1 = out_valid;
    endtask

    task automatic send_packet(
        input  logic [31:0] b,
        input  logic [31:0] a,
        input  logic [2:0]  op,
        input  int          nd,
        input  logic [3:0]  cx,
        output obs_t        o
    );
        logic [7:0]  bytes [9];
        logic [63:0] ba;
        ba = {b, a};
        for (int i = 0; i < 8; i++)
            bytes[i] = ba[63-8*i -: 8];
        bytes[8] = 8'h5A;
        for (int i = 0; i < nd; i++)
            send_frame(1'b0, bytes[i], 1'b1);
        send_frame(1'b1, {1'b0, op, crc_ref(b, a, op) ^ cx}, 1'b1);
        capture(o);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        sin = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({out_valid, ERR_FLAGS, OP, A, B} !== 74'd0) begin
            bad++;
            $display("FAIL reset_hold: got v=%b err=%b op=%b A=%h B=%h want all 0",
                     out_valid, ERR_FLAGS, OP, A, B);
        end
        rst = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if ({out_valid, ERR_FLAGS, OP, A, B} !== 74'd0 || nstrobe != 0) begin
            bad++;
            $display("FAIL reset_release: got v=%b err=%b strobes=%0d want 0",
                     out_valid, ERR_FLAGS, nstrobe);
        end
    endtask

    task automatic test_and;
        obs_t o;
        send_packet(32'h1, 32'h7, 3'b000, 8, 4'h0, o);
        total++;
        if ({o.v0, o.v1, o.err} !== {1'b1, 1'b0, 6'b000000}) begin
            bad++;
            $display("FAIL and_strobe: got v=%b%b err=%b want 10 000000",
                     o.v0, o.v1, o.err);
        end
        total++;
        if ({o.a, o.b, o.op} !== {32'h7, 32'h1, 3'b000}) begin
            bad++;
            $display("FAIL and_data: got A=%h B=%h op=%b want 7 1 000",
                     o.a, o.b, o.op);
        end
    endtask

    task automatic test_add;
        obs_t o;
        send_packet(32'hFFFFFFFF, 32'h1, 3'b100, 8, 4'h0, o);
        total++;
        if ({o.v0, o.v1, o.err} !== {1'b1, 1'b0, 6'b000000}) begin
            bad++;
            $display("FAIL add_strobe: got v=%b%b err=%b want 10 000000",
                     o.v0, o.v1, o.err);
        end
        total++;
        if ({o.a, o.b, o.op} !== {32'h1, 32'hFFFFFFFF, 3'b100}) begin
            bad++;
            $display("FAIL add_data: got A=%h B=%h op=%b want 1 ffffffff 100",
                     o.a, o.b, o.op);
        end
    endtask

    task automatic test_data_count;
        obs_t o;
        int   nds [3] = '{7, 9, 0};
        foreach (nds[k]) begin
            send_packet(32'h12345678, 32'h9ABCDEF0, 3'b001, nds[k], 4'h0, o);
            total++;
            if ({o.v0, o.v1, o.err} !== {1'b1, 1'b0, 6'b100100}) begin
                bad++;
                $display("FAIL data_count_%0d: got v=%b%b err=%b want 10 100100",
                         nds[k], o.v0, o.v1, o.err);
            end
        end
    endtask

    task automatic test_crc;
        obs_t o;
        send_packet(32'hCAFEBABE, 32'h0BADF00D, 3'b000, 8, 4'h1, o);
        total++;
        if ({o.v0, o.v1, o.err} !== {1'b1, 1'b0, 6'b010010}) begin
            bad++;
            $display("FAIL crc_bad: got v=%b%b err=%b want 10 010010",
                     o.v0, o.v1, o.err);
        end
        total++;
        if ({o.a, o.b} !== {32'h0BADF00D, 32'hCAFEBABE}) begin
            bad++;
            $display("FAIL crc_bad_ab: got A=%h B=%h want 0badf00d cafebabe",
                     o.a, o.b);
        end
        send_packet(32'hCAFEBABE, 32'h0BADF00D, 3'b111, 8, 4'h1, o);
        total++;
        if ({o.v0, o.v1, o.err} !== {1'b1, 1'b0, 6'b010010}) begin
            bad++;
            $display("FAIL crc_priority: got v=%b%b err=%b want 10 010010",
                     o.v0, o.v1, o.err);
        end
    endtask

    task automatic test_op;
        obs_t o;
        send_packet(32'h55, 32'hAA, 3'b010, 8, 4'h0, o);
        total++;
        if ({o.v0, o.v1, o.err} !== {1'b1, 1'b0, 6'b001001}) begin
            bad++;
            $display("FAIL op_bad: got v=%b%b err=%b want 10 001001",
                     o.v0, o.v1, o.err);
        end
    endtask

    task automatic test_framing;
        obs_t o;
        send_frame(1'b0, 8'h11, 1'b1);
        send_frame(1'b0, 8'h22, 1'b1);
        send_frame(1'b0, 8'h33, 1'b0);
        capture(o);
        total++;
        if ({o.v0, o.v1, o.err} !== {1'b1, 1'b0, 6'b100100}) begin
            bad++;
            $display("FAIL framing_err: got v=%b%b err=%b want 10 100100",
                     o.v0, o.v1, o.err);
        end
        repeat (3) send_bit(1'b1);
        send_packet(32'd9, 32'd23, 3'b101, 8, 4'h0, o);
        total++;
        if ({o.v0, o.v1, o.err, o.a, o.b, o.op} !==
            {1'b1, 1'b0, 6'b000000, 32'd23, 32'd9, 3'b101}) begin
            bad++;
            $display("FAIL framing_recover: got v=%b%b err=%b A=%h B=%h op=%b want 10 0 17 9 101",
                     o.v0, o.v1, o.err, o.a, o.b, o.op);
        end
    endtask

    task automatic test_reset_mid;
        obs_t o;
        int   n0;
        n0 = nstrobe;
        for (int i = 0; i < 4; i++)
            send_frame(1'b0, 8'hC3, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({out_valid, ERR_FLAGS, OP, A, B} !== 74'd0) begin
            bad++;
            $display("FAIL reset_mid_clear: got v=%b err=%b op=%b A=%h B=%h want all 0",
                     out_valid, ERR_FLAGS, OP, A, B);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        sin = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if (nstrobe != n0) begin
            bad++;
            $display("FAIL reset_mid_nostrobe: got strobes=%0d want %0d", nstrobe, n0);
        end
        send_packet(32'hDEAD0001, 32'hBEEF0002, 3'b001, 8, 4'h0, o);
        total++;
        if ({o.v0, o.v1, o.err, o.a, o.b, o.op} !==
            {1'b1, 1'b0, 6'b000000, 32'hBEEF0002, 32'hDEAD0001, 3'b001}
            || nstrobe != n0 + 1) begin
            bad++;
            $display("FAIL reset_mid_packet: got v=%b%b err=%b A=%h B=%h op=%b strobes=%0d want 10 0 beef0002 dead0001 001 %0d",
                     o.v0, o.v1, o.err, o.a, o.b, o.op, nstrobe, n0 + 1);
        end
    endtask

    task automatic test_random;
        obs_t        o;
        logic [31:0] a, b;
        logic [2:0]  op;
        logic [3:0]  cx;
        logic [5:0]  e;
        int          nd, r, n0;
        n0 = nstrobe;
        for (int it = 0; it < 40; it++) begin
            a  = $urandom;
            b  = $urandom;
            op = 3'($urandom_range(0, 7));
            r  = $urandom_range(0, 9);
            nd = (r == 0) ? 7 : (r == 1) ? 9 : (r == 2) ? 0 : 8;
            cx = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            e  = exp_err(nd, cx, op);
            send_packet(b, a, op, nd, cx, o);
            total++;
            if ({o.v0, o.v1, o.err} !== {1'b1, 1'b0, e}) begin
                bad++;
                $display("FAIL rand_err[%0d]: got v=%b%b err=%b want 10 %b (nd=%0d cx=%h op=%b)",
                         it, o.v0, o.v1, o.err, e, nd, cx, op);
            end
            if (nd == 8) begin
                total++;
                if ({o.a, o.b} !== {a, b}) begin
                    bad++;
                    $display("FAIL rand_ab[%0d]: got A=%h B=%h want %h %h",
                             it, o.a, o.b, a, b);
                end
            end
            if (e == 6'b000000) begin
                total++;
                if (o.op !== op) begin
                    bad++;
                    $display("FAIL rand_op[%0d]: got %b want %b", it, o.op, op);
                end
            end
        end
        total++;
        if (nstrobe != n0 + 40) begin
            bad++;
            $display("FAIL rand_strobes: got %0d want %0d", nstrobe - n0, 40);
        end
    endtask

    initial begin
        test_reset();
        test_and();
        test_add();
        test_data_count();
        test_crc();
        test_op();
        test_framing();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
